// File: rtl/alu_exec_unit_if.sv
// Handshake and status bundle for alu_exec_unit.
// The slave modport is the ALU side; the master modport is the upstream/consumer side.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             op_err;
    logic             clear_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, ALU_control, operand_a, operand_b, out_ready, clear_err,
        output in_ready, out_valid, result, zero, op_err, err_sticky, err_count
    );

    modport master (
        output in_valid, ALU_control, operand_a, operand_b, out_ready, clear_err,
        input  in_ready, out_valid, result, zero, op_err, err_sticky, err_count
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready input, a 2-entry result FIFO and
// sticky/saturating illegal-opcode status.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_ERR = 4'b1111;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    occ_t             r_occ;
    occ_t             w_occ_nxt;
    logic             r_head;
    logic             r_tail;
    logic [WIDTH-1:0] r_res  [2];
    logic             r_zero [2];
    logic             r_err  [2];
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_res;
    logic             w_illegal;
    logic             w_zero;
    logic             w_cnt_sat;

    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (bus.ALU_control)
            ALU_ADD: w_res = bus.operand_a + bus.operand_b;
            ALU_SUB: w_res = bus.operand_a - bus.operand_b;
            ALU_AND: w_res = bus.operand_a & bus.operand_b;
            ALU_OR:  w_res = bus.operand_a | bus.operand_b;
            ALU_ERR: w_illegal = 1'b1;
            default: w_illegal = 1'b1;
        endcase
        w_zero = !w_illegal && (w_res == '0);
    end

    // in_ready depends only on registered occupancy (and rst), never on out_ready
    assign w_in_ready  = !rst && (r_occ != OCC_FULL);
    assign w_out_valid = (r_occ != OCC_EMPTY);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_cnt_sat   = &r_err_count;

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_push) w_occ_nxt = OCC_ONE;
            end
            OCC_ONE: begin
                if (w_push && !w_pop)      w_occ_nxt = OCC_FULL;
                else if (!w_push && w_pop) w_occ_nxt = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (w_pop) w_occ_nxt = OCC_ONE;
            end
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_occ <= OCC_EMPTY;
        else     r_occ <= w_occ_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_res[i]  <= '0;
                r_zero[i] <= 1'b0;
                r_err[i]  <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_res[r_tail]  <= w_res;
                r_zero[r_tail] <= w_zero;
                r_err[r_tail]  <= w_illegal;
                r_tail         <= ~r_tail;
            end
            if (w_pop) r_head <= ~r_head;
        end
    end

    // An accepted illegal op takes priority over clear_err, restarting the count at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_push && w_illegal) begin
            r_err_sticky <= 1'b1;
            if (bus.clear_err)  r_err_count <= CNT_W'(1);
            else if (!w_cnt_sat) r_err_count <= r_err_count + CNT_W'(1);
        end else if (bus.clear_err) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.result     = w_out_valid ? r_res[r_head]  : '0;
    assign bus.zero       = w_out_valid ? r_zero[r_head] : 1'b0;
    assign bus.op_err     = w_out_valid ? r_err[r_head]  : 1'b0;
    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: arithmetic wrap, logic ops,
// backpressure, illegal codes, error status and reset mid-stream.
module tb_alu_exec_unit;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_ERR = 4'b1111;
    localparam logic [3:0] C_UND = 4'b0101;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_exec_unit_if #(.WIDTH(32), .CNT_W(8)) bus ();

    alu_exec_unit #(.WIDTH(32), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid    = 1'b1;
        bus.ALU_control = code;
        bus.operand_a   = a;
        bus.operand_b   = b;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.ALU_control = C_ADD;
        bus.operand_a   = '0;
        bus.operand_b   = '0;
        bus.out_ready   = 1'b0;
        bus.clear_err   = 1'b0;

        tick();
        tick();
        check("in_ready_during_rst", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",   64'(bus.in_ready),   64'd1);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_result",     64'(bus.result),     64'd0);
        check("rst_zero",       64'(bus.zero),       64'd0);
        check("rst_op_err",     64'(bus.op_err),     64'd0);
        check("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
        check("rst_err_count",  64'(bus.err_count),  64'd0);

        // ADD wrap to zero
        bus.out_ready = 1'b1;
        offer(C_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        bus.in_valid = 1'b0;
        check("add_valid",  64'(bus.out_valid), 64'd1);
        check("add_result", 64'(bus.result),    64'h0);
        check("add_zero",   64'(bus.zero),      64'd1);
        check("add_op_err", 64'(bus.op_err),    64'd0);
        tick();
        check("add_drained", 64'(bus.out_valid), 64'd0);

        // SUB wrap to all ones
        offer(C_SUB, 32'h0000_0000, 32'h0000_0001);
        tick();
        bus.in_valid = 1'b0;
        check("sub_result", 64'(bus.result), 64'hFFFF_FFFF);
        check("sub_zero",   64'(bus.zero),   64'd0);
        tick();

        // AND then OR back to back
        offer(C_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        tick();
        offer(C_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        check("and_result", 64'(bus.result), 64'h00F0_000F);
        tick();
        bus.in_valid = 1'b0;
        check("or_result", 64'(bus.result),    64'hFFF0_0FFF);
        check("or_valid",  64'(bus.out_valid), 64'd1);
        tick();
        check("logic_drained", 64'(bus.out_valid), 64'd0);

        // Backpressure: two accepted, third stalls until the first pop
        bus.out_ready = 1'b0;
        offer(C_ADD, 32'd1, 32'd1);
        tick();
        offer(C_SUB, 32'd10, 32'd3);
        tick();
        check("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_head1",         64'(bus.result),   64'd2);
        offer(C_OR, 32'h100, 32'h001);
        tick();
        check("bp_still_full", 64'(bus.in_ready), 64'd0);
        check("bp_head1_held", 64'(bus.result),   64'd2);
        bus.out_ready = 1'b1;
        tick();
        check("bp_head2",        64'(bus.result),   64'd7);
        check("bp_ready_reopen", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_head3",  64'(bus.result),    64'h101);
        check("bp_valid3", 64'(bus.out_valid), 64'd1);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Illegal codes: ALU_ERR then an undefined encoding
        bus.out_ready = 1'b0;
        offer(C_ERR, 32'd5, 32'd6);
        tick();
        check("ill_count_on_accept", 64'(bus.err_count),  64'd1);
        check("ill_sticky",          64'(bus.err_sticky), 64'd1);
        check("ill1_result",         64'(bus.result),     64'd0);
        check("ill1_op_err",         64'(bus.op_err),     64'd1);
        check("ill1_zero",           64'(bus.zero),       64'd0);
        offer(C_UND, 32'd7, 32'd7);
        tick();
        bus.in_valid = 1'b0;
        check("ill_count2", 64'(bus.err_count), 64'd2);
        bus.out_ready = 1'b1;
        tick();
        check("ill2_valid",  64'(bus.out_valid), 64'd1);
        check("ill2_result", 64'(bus.result),    64'd0);
        check("ill2_op_err", 64'(bus.op_err),    64'd1);
        check("ill2_zero",   64'(bus.zero),      64'd0);
        tick();
        check("ill_drained",    64'(bus.out_valid), 64'd0);
        check("ill_op_err_off", 64'(bus.op_err),    64'd0);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check("clr_count",  64'(bus.err_count),  64'd0);
        check("clr_sticky", 64'(bus.err_sticky), 64'd0);

        // Clear coinciding with an accepted illegal op
        offer(C_ERR, 32'd0, 32'd0);
        repeat (5) tick();
        check("cnt5", 64'(bus.err_count), 64'd5);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check("clr_vs_err_count",  64'(bus.err_count),  64'd1);
        check("clr_vs_err_sticky", 64'(bus.err_sticky), 64'd1);

        // Saturation at 255
        repeat (260) tick();
        check("cnt_saturated", 64'(bus.err_count), 64'd255);
        bus.in_valid  = 1'b0;
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        check("sat_cleared", 64'(bus.err_count), 64'd0);
        check("sat_drained", 64'(bus.out_valid), 64'd0);

        // Illegal op offered while full is ignored
        bus.out_ready = 1'b0;
        offer(C_ADD, 32'd1, 32'd1);
        tick();
        tick();
        offer(C_ERR, 32'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("rej_count",  64'(bus.err_count),  64'd0);
        check("rej_sticky", 64'(bus.err_sticky), 64'd0);

        // Reset with two entries buffered
        rst = 1'b1;
        tick();
        check("mrst_in_ready",  64'(bus.in_ready),  64'd0);
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready),  64'd1);
        check("post_rst_valid",    64'(bus.out_valid), 64'd0);
        check("post_rst_result",   64'(bus.result),    64'd0);
        check("post_rst_op_err",   64'(bus.op_err),    64'd0);
        tick();
        check("post_rst_still_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        offer(C_ADD, 32'd2, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_add",  64'(bus.result), 64'd5);
        check("post_rst_zero", 64'(bus.zero),   64'd0);
        tick();
        check("post_rst_drained", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
